pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, flush, and a saturating back-pressure counter. It is the next-generation replacement for the fixed-field stage registers between EX/MEM and MEM/WB. Each instance carries one control bundle and one data bundle, and can stall or be flushed. An optional skid buffer breaks the combinational ready path.

## Interface
Parameters:
- CTRL_W, 5, width of control bundle (RegWrite, MemRead, MemWrite, MemtoReg, lui_sig class); zeroed on reset and flush
- DATA_W, 107, width of data payload (alu_result, rdata_b, opcode, imme_num, wreg class); zeroed on reset only
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream stage holds a valid instruction
- in_ready  out  1  this stage accepts on this cycle when in_valid && in_ready
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream data bundle
- flush  in  1  kill all held and incoming contents (branch/exception)
- out_valid  out  1  out_ctrl/out_data hold a valid instruction
- out_ready  in  1  downstream consumes when out_valid && out_ready
- out_ctrl  out  CTRL_W  registered control bundle
- out_data  out  DATA_W  registered data bundle
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

## Operation
- Reset (rst=1 at posedge): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid entry empty and zeroed. In base build in_ready=1 after reset. With skid, in_ready=1 after reset.
- Accept: in_valid && in_ready at posedge loads in_ctrl/in_data into the output entry. If out_valid && out_ready and there is no accept, out_valid clears. out_ctrl is forced to 0 whenever out_valid=0 after a consume. out_data holds its last value.
- Stall: out_valid && !out_ready holds out_* unchanged. No new accept occurs in the base build.
- Flush: flush=1 at posedge clears out_valid, out_ctrl and the skid entry, and drops any same-cycle input beat, even if it was accepted. Priority: rst > flush > accept/consume.
- Base build: in_ready = !out_valid || out_ready (combinational).
- stall_cnt: +1 on every posedge with out_valid && !out_ready && !flush. Holds at 2^CNT_W-1. Only rst clears it.

## Timing
- Latency: one cycle from accept to out_valid=1.
- Throughput: one beat per cycle while out_ready=1.
- Simultaneous accept and consume on a full stage: the new beat replaces the old one with no bubble.
- Flush during a stall: the next cycle shows out_valid=0, and in_ready=1 in both builds.
- Reset mid-stall: all outputs return to reset values on the next cycle. stall_cnt=0.
- Data is never lost or duplicated. Each accepted beat is presented exactly once unless it is flushed.

## Configuration
- PIPE_SKID_EN defined: a second (skid) entry is added, and in_ready is a register equal to !skid_valid.
  - States: EMPTY (out_valid=0), FULL (out_valid=1, skid empty), SKID (both valid).
  - EMPTY -> FULL on accept.
  - FULL -> SKID on accept && !out_ready.
  - FULL -> EMPTY on consume without accept.
  - SKID -> FULL on consume: the skid entry moves to the output and in_ready rises next cycle.
  - Any state -> EMPTY on flush or rst.
  - Ordering is strictly FIFO.
- PIPE_SKID_EN undefined: single entry with a combinational in_ready as above. The skid logic and its state are absent.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 and in_ctrl=5'h1F. Require out_valid=0, out_ctrl=0, out_data=0 and stall_cnt=0 on release.
- Streaming: 8 beats with data 1..8 and out_ready=1. Require out_data 1..8 on consecutive cycles, each one cycle after its accept, with no bubbles.
- Stall: hold out_ready=0 for 5 cycles with beat 0xA valid.
  - Require out_data=0xA held and stall_cnt=5.
  - Base build: in_ready=0.
  - Skid build: exactly one extra beat 0xB accepted, then in_ready=0.
  - Release: require 0xA then 0xB.
- Flush: assert flush together with in_valid=1 and in_ctrl=5'h1F. Require out_valid=0 and out_ctrl=0 next cycle, the dropped beat never appears, and in_ready=1.
- Saturation: CNT_W=4 with out_ready=0 for 20 cycles. Require stall_cnt=15 held. A subsequent flush leaves stall_cnt at 15.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and a saturating stall counter.
// Define PIPE_SKID_EN to add a skid entry that makes in_ready a registered signal.
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 107,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              valid_now;
  logic              accept;

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  assign valid_now = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = EMPTY;
      out_ctrl_d  = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = FULL;
            out_ctrl_d = in_ctrl;
            out_data_d = in_data;
          end
        end
        FULL: begin
          if (accept && out_ready) begin
            out_ctrl_d = in_ctrl;
            out_data_d = in_data;
          end else if (accept) begin
            state_d     = SKID;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_ready) begin
            state_d    = EMPTY;
            out_ctrl_d = '0;
          end
        end
        SKID: begin
          // The held skid beat becomes the head; upstream reopens one cycle later.
          if (out_ready) begin
            state_d     = FULL;
            out_ctrl_d  = skid_ctrl_q;
            out_data_d  = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  logic out_valid_q, out_valid_d;

  assign valid_now = out_valid_q;
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_ctrl_d  = in_ctrl;
      out_data_d  = in_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= out_valid_d;
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_now && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = valid_now;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule
